// File: rtl/gcd_control.sv
// gcd_control: sequencing FSM for the subtractive GCD datapath with busy/done/err reporting
module gcd_control #(
    parameter int W        = 4,
    parameter int MAX_ITER = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] xin,
    input  logic [W-1:0] yin,
    input  logic         ltflag,
    input  logic         eqflag,
    output logic         xsel,
    output logic         ysel,
    output logic         xld,
    output logic         yld,
    output logic         gld,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W:0]   iter_cnt
);
    localparam logic [W:0] MAX = (W+1)'(MAX_ITER);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    state_t     r_state, w_next;
    logic       r_err;
    logic [W:0] r_cnt;
    logic       w_clr, w_inc, w_set;

    // next state and strobes; the RUN branch is Mealy on the datapath flags, bound checked before subtracting
    always_comb begin
        w_next = r_state;
        xsel   = 1'b0;
        ysel   = 1'b0;
        xld    = 1'b0;
        yld    = 1'b0;
        gld    = 1'b0;
        w_clr  = 1'b0;
        w_inc  = 1'b0;
        w_set  = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_clr  = 1'b1;
                w_set  = (xin == '0) || (yin == '0);
                w_next = w_set ? DONE : LOAD;
            end
            LOAD: begin
                xsel   = 1'b1;
                ysel   = 1'b1;
                xld    = 1'b1;
                yld    = 1'b1;
                w_next = RUN;
            end
            RUN: if (eqflag) begin
                gld    = 1'b1;
                w_next = DONE;
            end else if (r_cnt == MAX) begin
                w_set  = 1'b1;
                w_next = DONE;
            end else begin
                yld    = ltflag;
                xld    = ~ltflag;
                w_inc  = 1'b1;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // subtraction counter and sticky error; error set wins over the clear of an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_clr)      r_cnt <= '0;
            else if (w_inc) r_cnt <= r_cnt + 1'b1;
            if (w_set)      r_err <= 1'b1;
            else if (w_clr) r_err <= 1'b0;
        end
    end

    assign busy     = (r_state == LOAD) || (r_state == RUN);
    assign done     = (r_state == DONE);
    assign err      = r_err;
    assign iter_cnt = r_cnt;
endmodule
